// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: pipeline-to-data-memory bus between the M stage and the store buffer.
//   master: memWriteM, memReadM, aluResultM (byte address), writeData drive out; readDataM, stallM, sbCount, sbEmpty come back
//   slave : the mirror image, used by dmem_store_buffer
interface dmem_store_buffer_if #(
    parameter int WIDTH = 32,
    parameter int SBUF  = 4
);
    localparam int CW = $clog2(SBUF) + 1;
    logic             memWriteM;
    logic             memReadM;
    logic [WIDTH-1:0] aluResultM;
    logic [WIDTH-1:0] writeData;
    logic [WIDTH-1:0] readDataM;
    logic             stallM;
    logic [CW-1:0]    sbCount;
    logic             sbEmpty;
    modport master (
        output memWriteM, memReadM, aluResultM, writeData,
        input  readDataM, stallM, sbCount, sbEmpty
    );
    modport slave (
        input  memWriteM, memReadM, aluResultM, writeData,
        output readDataM, stallM, sbCount, sbEmpty
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: word-addressed data RAM fronted by a circular store buffer with youngest-match load forwarding.
//   clk   : rising-edge clock for all state
//   reset : asynchronous active-high; empties the buffer and zeroes the RAM
//   bus   : dmem_store_buffer_if.slave (store/load requests in; load data, stall, occupancy out)
module dmem_store_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int SBUF  = 4
) (
    input logic                clk,
    input logic                reset,
    dmem_store_buffer_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (SBUF > 1) ? $clog2(SBUF) : 1;
    localparam int CW = $clog2(SBUF) + 1;
    logic [WIDTH-1:0] ram [DEPTH];
    logic [IW-1:0]    idx_q [SBUF];
    logic [WIDTH-1:0] dat_q [SBUF];
    logic [PW-1:0]    head, tail, pos;
    logic [CW-1:0]    count;
    logic [IW-1:0]    idx;
    logic             full, accept, drain, fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic             unused_addr;
    assign idx         = bus.aluResultM[IW+1:2];
    assign unused_addr = ^{bus.aluResultM[1:0], bus.aluResultM[WIDTH-1:IW+2]};
    assign full        = count == CW'(SBUF);
    assign accept      = bus.memWriteM && !full;
    // A load normally wins the RAM port, except when the buffer is full: then the
    // head must retire so a stalled store can enter on the very next cycle.
    assign drain       = count != '0 && (!bus.memReadM || full);
    assign bus.stallM  = bus.memWriteM && full;
    assign bus.sbCount = count;
    assign bus.sbEmpty = count == '0;
    // Scan oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        pos      = '0;
        for (int i = 0; i < SBUF; i++) begin
            pos = PW'((int'(head) + i) % SBUF);
            if (i < int'(count) && idx_q[pos] == idx) begin
                fwd_hit  = 1'b1;
                fwd_data = dat_q[pos];
            end
        end
    end
    // The incoming store is not yet in the buffer, so a combined store+load sees the pre-store value.
    assign bus.readDataM = fwd_hit ? fwd_data : ram[idx];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) tail <= PW'((int'(tail) + 1) % SBUF);
            if (drain) head <= PW'((int'(head) + 1) % SBUF);
            if (accept && !drain) count <= count + 1'b1;
            else if (!accept && drain) count <= count - 1'b1;
        end
    end
    // Entry payload needs no reset: validity comes only from head/count.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q[tail] <= idx;
            dat_q[tail] <= bus.writeData;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else if (drain) begin
            ram[idx_q[head]] <= dat_q[head];
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: table-driven check of dmem_store_buffer (SBUF=4, DEPTH=64) with a scoreboard queue.
module tb_dmem_store_buffer;
    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        estall;
        logic [2:0]  ecnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl [38];
    vec_t sb [$];

    always #5 clk = ~clk;

    dmem_store_buffer_if #(.WIDTH(32), .SBUF(4)) bus ();
    dmem_store_buffer #(.WIDTH(32), .DEPTH(64), .SBUF(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic vec_t v(logic wr, logic rd, logic [31:0] addr, logic [31:0] wd,
                               logic [31:0] erd, logic estall, logic [2:0] ecnt);
        vec_t t;
        t.wr = wr; t.rd = rd; t.addr = addr; t.wd = wd;
        t.erd = erd; t.estall = estall; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wd);
        bus.memWriteM  = wr;
        bus.memReadM   = rd;
        bus.aluResultM = addr;
        bus.writeData  = wd;
    endtask

    // One cycle: drive after the edge, queue the expectation, check it mid-cycle.
    task automatic apply(input string tag, input vec_t t);
        vec_t e;
        @(posedge clk);
        #1;
        drive(t.wr, t.rd, t.addr, t.wd);
        sb.push_back(t);
        @(negedge clk);
        e = sb.pop_front();
        cmp({tag, " readDataM"}, bus.readDataM, e.erd);
        cmp({tag, " stallM"}, {31'd0, bus.stallM}, {31'd0, e.estall});
        cmp({tag, " sbCount"}, {29'd0, bus.sbCount}, {29'd0, e.ecnt});
        cmp({tag, " sbEmpty"}, {31'd0, bus.sbEmpty}, {31'd0, e.ecnt == 3'd0});
    endtask

    initial begin
        // load after reset
        tbl[0]  = v(0, 1, 32'h10, 0, 32'h0, 0, 0);
        // store then forwarded load, then drain
        tbl[1]  = v(1, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0, 0);
        tbl[2]  = v(0, 1, 32'h20, 0, 32'hDEADBEEF, 0, 1);
        tbl[3]  = v(0, 0, 32'h20, 0, 32'hDEADBEEF, 0, 1);
        tbl[4]  = v(0, 1, 32'h20, 0, 32'hDEADBEEF, 0, 0);
        // back-to-back stores to one word
        tbl[5]  = v(1, 0, 32'h40, 32'h1, 32'h0, 0, 0);
        tbl[6]  = v(1, 0, 32'h40, 32'h2, 32'h1, 0, 1);
        tbl[7]  = v(0, 1, 32'h40, 0, 32'h2, 0, 1);
        tbl[8]  = v(0, 0, 32'h40, 0, 32'h2, 0, 1);
        tbl[9]  = v(0, 1, 32'h40, 0, 32'h2, 0, 0);
        // fill with loads held, stall on the fifth store, then drain all
        tbl[10] = v(1, 1, 32'h80, 32'hA0, 32'h0, 0, 0);
        tbl[11] = v(1, 1, 32'h84, 32'hA1, 32'h0, 0, 1);
        tbl[12] = v(1, 1, 32'h88, 32'hA2, 32'h0, 0, 2);
        tbl[13] = v(1, 1, 32'h8C, 32'hA3, 32'h0, 0, 3);
        tbl[14] = v(1, 1, 32'h90, 32'hA4, 32'h0, 1, 4);
        tbl[15] = v(1, 1, 32'h90, 32'hA4, 32'h0, 0, 3);
        tbl[16] = v(0, 0, 32'h88, 0, 32'hA2, 0, 4);
        tbl[17] = v(0, 0, 32'h00, 0, 32'h0, 0, 3);
        tbl[18] = v(0, 0, 32'h00, 0, 32'h0, 0, 2);
        tbl[19] = v(0, 0, 32'h00, 0, 32'h0, 0, 1);
        tbl[20] = v(0, 1, 32'h80, 0, 32'hA0, 0, 0);
        tbl[21] = v(0, 1, 32'h84, 0, 32'hA1, 0, 0);
        tbl[22] = v(0, 1, 32'h88, 0, 32'hA2, 0, 0);
        tbl[23] = v(0, 1, 32'h8C, 0, 32'hA3, 0, 0);
        tbl[24] = v(0, 1, 32'h90, 0, 32'hA4, 0, 0);
        // loads block the drain while the buffer is not full
        tbl[25] = v(1, 0, 32'h04, 32'h55, 32'h0, 0, 0);
        tbl[26] = v(0, 1, 32'h08, 0, 32'h0, 0, 1);
        tbl[27] = v(0, 1, 32'h08, 0, 32'h0, 0, 1);
        tbl[28] = v(0, 1, 32'h08, 0, 32'h0, 0, 1);
        tbl[29] = v(0, 0, 32'h04, 0, 32'h55, 0, 1);
        tbl[30] = v(0, 1, 32'h04, 0, 32'h55, 0, 0);
        // byte offset and upper address bits are ignored
        tbl[31] = v(0, 1, 32'hFFFFFF07, 0, 32'h55, 0, 0);
        // youngest match wins; RAM ends with the younger value
        tbl[32] = v(1, 1, 32'h60, 32'h11, 32'h0, 0, 0);
        tbl[33] = v(1, 1, 32'h60, 32'h22, 32'h11, 0, 1);
        tbl[34] = v(0, 1, 32'h60, 0, 32'h22, 0, 2);
        tbl[35] = v(0, 0, 32'h60, 0, 32'h22, 0, 2);
        tbl[36] = v(0, 0, 32'h60, 0, 32'h22, 0, 1);
        tbl[37] = v(0, 1, 32'h60, 0, 32'h22, 0, 0);

        drive(0, 0, 32'h10, 0);
        #2;
        cmp("in_reset sbCount", {29'd0, bus.sbCount}, 32'd0);
        cmp("in_reset sbEmpty", {31'd0, bus.sbEmpty}, 32'd1);
        cmp("in_reset readDataM", bus.readDataM, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 38; i++) apply($sformatf("row%0d", i), tbl[i]);

        // reset mid-operation discards pending stores
        apply("pend0", v(1, 1, 32'hC0, 32'h71, 32'h0, 0, 0));
        apply("pend1", v(1, 1, 32'hC4, 32'h72, 32'h0, 0, 1));
        apply("pend2", v(1, 1, 32'hC8, 32'h73, 32'h0, 0, 2));
        @(posedge clk);
        #1;
        drive(0, 0, 32'hC0, 0);
        cmp("pre_reset sbCount", {29'd0, bus.sbCount}, 32'd3);
        reset = 1'b1;
        #1;
        cmp("async_reset sbCount", {29'd0, bus.sbCount}, 32'd0);
        cmp("async_reset readDataM", bus.readDataM, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        apply("post_rst0", v(0, 1, 32'hC0, 0, 32'h0, 0, 0));
        apply("post_rst1", v(0, 1, 32'hC4, 0, 32'h0, 0, 0));
        apply("post_rst2", v(0, 1, 32'hC8, 0, 32'h0, 0, 0));
        apply("post_rst3", v(0, 1, 32'h20, 0, 32'h0, 0, 0));
        apply("post_rst4", v(0, 0, 32'h40, 0, 32'h0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
